// File: rtl/battleship_pkg.sv
// Shared battleship types, board geometry and cell codes.
// Index helpers map a row-major cell index to row/column.
package battleship_pkg;

  localparam int BOARD_N   = 5;
  localparam int CELLS     = 25;
  localparam int CELL_BITS = 5;

  localparam int CODE_EMPTY             = 0;
  localparam int CODE_MISS              = 9;
  localparam int CODE_PC_HIT            = 6;
  localparam int CODE_PLAYER_HIT_OFFSET = 10;

  typedef logic [CELL_BITS-1:0] cell_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    HUNT,
    ISSUE,
    FINISH
  } sel_state_e;

  function automatic logic [2:0] idx_row(
    input logic [4:0] i
  );
    return 3'(i / 5'd5);
  endfunction

  function automatic logic [2:0] idx_col(
    input logic [4:0] i
  );
    return 3'(i % 5'd5);
  endfunction

  // Fold a 5-bit random value into 0..24.
  function automatic logic [4:0] fold_idx(
    input logic [4:0] r
  );
    return (r >= 5'd25) ? r - 5'd25 : r;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4, seeded on reset.
// Ports: clk, rst (async high), en (step enable), q (state).
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  logic fb;

  assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[6:0], fb};
    end
  end

endmodule

// File: rtl/pc_target_selector.sv
// PC target picker: random start + linear scan to first unattacked
// cell, then a held attack_req handshake. Optional macro HUNT_MODE_EN
// adds neighbour probing around the last PC hit.
// Ports: clk, rst (async high), start, board (25 cells, row-major),
// row/col/attack_req/attack_done to the attack stage, busy, done,
// no_target status back to the turn controller.
module pc_target_selector
  import battleship_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED   = 8'hA5,
  parameter int         CELL_W      = 5,
  parameter int         MISS_CODE   = 9,
  parameter int         PC_HIT_CODE = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [25*CELL_W-1:0]  board,
  output logic [2:0]            row,
  output logic [2:0]            col,
  output logic                  attack_req,
  input  logic                  attack_done,
  output logic                  busy,
  output logic                  done,
  output logic                  no_target
);

  localparam logic [CELL_W-1:0] MISS_C = CELL_W'(MISS_CODE);
  localparam logic [CELL_W-1:0] HIT_C  = CELL_W'(PC_HIT_CODE);

  sel_state_e state;

  logic [4:0] idx;
  logic [4:0] cnt;
  logic [7:0] lfsr_q;
  logic [4:0] start_idx;
  logic [CELL_W-1:0] cur_cell;
  logic unused_lfsr;

  function automatic logic can_hit(
    input logic [CELL_W-1:0] v
  );
    return (v != MISS_C) && (v != HIT_C);
  endfunction

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .q   (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[7:5];
  assign start_idx   = fold_idx(lfsr_q[4:0]);
  assign cur_cell    = board[int'(idx)*CELL_W +: CELL_W];

`ifdef HUNT_MODE_EN
  logic [4:0] hunt_idx;
  logic       hunt_valid;
  logic [1:0] hunt_dir;
  logic [4:0] nb_idx;
  logic       nb_ok;
  logic [4:0] nb_sel;
  logic [CELL_W-1:0] nb_cell;

  // Neighbour probe order N, S, W, E; off-board yields nb_ok=0.
  always_comb begin
    nb_idx = hunt_idx;
    nb_ok  = 1'b0;
    unique case (hunt_dir)
      2'd0: begin
        nb_ok  = idx_row(hunt_idx) != 3'd0;
        nb_idx = hunt_idx - 5'd5;
      end
      2'd1: begin
        nb_ok  = idx_row(hunt_idx) != 3'd4;
        nb_idx = hunt_idx + 5'd5;
      end
      2'd2: begin
        nb_ok  = idx_col(hunt_idx) != 3'd0;
        nb_idx = hunt_idx - 5'd1;
      end
      default: begin
        nb_ok  = idx_col(hunt_idx) != 3'd4;
        nb_idx = hunt_idx + 5'd1;
      end
    endcase
    nb_sel  = nb_ok ? nb_idx : 5'd0;
    nb_cell = board[int'(nb_sel)*CELL_W +: CELL_W];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      row        <= '0;
      col        <= '0;
      attack_req <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      no_target  <= 1'b0;
`ifdef HUNT_MODE_EN
      hunt_idx   <= '0;
      hunt_valid <= 1'b0;
      hunt_dir   <= '0;
`endif
    end else begin
      done      <= 1'b0;
      no_target <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            idx  <= start_idx;
            cnt  <= '0;
            busy <= 1'b1;
`ifdef HUNT_MODE_EN
            hunt_dir <= '0;
            state    <= hunt_valid ? HUNT : SCAN;
`else
            state <= SCAN;
`endif
          end
        end
        SCAN: begin
          if (can_hit(cur_cell)) begin
            row        <= idx_row(idx);
            col        <= idx_col(idx);
            attack_req <= 1'b1;
            state      <= ISSUE;
          end else begin
            idx <= (idx == 5'd24) ? 5'd0 : idx + 5'd1;
            cnt <= cnt + 5'd1;
            // 25th blocked cell: the board is exhausted.
            if (cnt == 5'd24) begin
              no_target <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
`ifdef HUNT_MODE_EN
        HUNT: begin
          if (nb_ok && can_hit(nb_cell)) begin
            idx        <= nb_idx;
            row        <= idx_row(nb_idx);
            col        <= idx_col(nb_idx);
            attack_req <= 1'b1;
            state      <= ISSUE;
          end else if (hunt_dir == 2'd3) begin
            hunt_valid <= 1'b0;
            state      <= SCAN;
          end else begin
            hunt_dir <= hunt_dir + 2'd1;
          end
        end
`endif
        ISSUE: begin
          if (attack_done) begin
            attack_req <= 1'b0;
            done       <= 1'b1;
            state      <= FINISH;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
`ifdef HUNT_MODE_EN
          // The attack stage has already written the fired cell.
          if (cur_cell == HIT_C) begin
            hunt_idx   <= idx;
            hunt_valid <= 1'b1;
          end else begin
            hunt_valid <= 1'b0;
          end
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_target_selector.sv
// Self-checking bench for pc_target_selector.
// Directed vector table plus hand-written multi-cycle sequences.
module tb_pc_target_selector;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [124:0] board;
  logic [2:0]   row;
  logic [2:0]   col;
  logic         attack_req;
  logic         attack_done;
  logic         busy;
  logic         done;
  logic         no_target;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_target_selector dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .board       (board),
    .row         (row),
    .col         (col),
    .attack_req  (attack_req),
    .attack_done (attack_done),
    .busy        (busy),
    .done        (done),
    .no_target   (no_target)
  );

  typedef struct {
    logic [24:0] mm;
    logic [24:0] hm;
    int lat;
    int d;
    int er;
    int ec;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [124:0] mk(
    input logic [24:0] mm,
    input logic [24:0] hm
  );
    logic [124:0] b;
    b = '0;
    for (int i = 0; i < 25; i++) begin
      if (hm[i]) b[i*5 +: 5] = 5'd6;
      else if (mm[i]) b[i*5 +: 5] = 5'd9;
    end
    return b;
  endfunction

  function automatic logic [7:0] lstep(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    attack_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulse start on the next edge, wait for attack_req; returns cycle.
  task automatic wait_req(output int rc);
    int c;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 0;
    rc = -1;
    while (rc < 0 && c < 40) begin
      @(negedge clk);
      c++;
      if (attack_req) rc = c;
    end
    if (rc < 0) begin
      total++;
      bad++;
      $display("FAIL req_timeout: got none want attack_req");
    end
  endtask

  task automatic run_vec(input int n);
    vec_t v;
    int c;
    int rc;
    v = vt[n];
    do_reset();
    board = mk(v.mm, v.hm);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 0;
    rc = -1;
    while (rc < 0 && c < 40) begin
      @(negedge clk);
      c++;
      if (c == 1) chk($sformatf("v%0d_busy1", n), busy, 1);
      if (attack_req) rc = c;
    end
    chk($sformatf("v%0d_lat", n), rc, v.lat);
    chk($sformatf("v%0d_row", n), row, v.er);
    chk($sformatf("v%0d_col", n), col, v.ec);
    repeat (v.d) @(negedge clk);
    attack_done = 1'b1;
    @(negedge clk);
    attack_done = 1'b0;
    chk($sformatf("v%0d_done", n), done, 1);
    chk($sformatf("v%0d_req_off", n), attack_req, 0);
    @(negedge clk);
    chk($sformatf("v%0d_done_off", n), done, 0);
    chk($sformatf("v%0d_busy_off", n), busy, 0);
  endtask

`ifdef HUNT_MODE_EN
  task automatic fire(
    input string nm,
    input int er,
    input int ec,
    input int hit_cell
  );
    int rc;
    wait_req(rc);
    chk({nm, "_row"}, row, er);
    chk({nm, "_col"}, col, ec);
    if (hit_cell >= 0) board[hit_cell*5 +: 5] = 5'd6;
    attack_done = 1'b1;
    @(negedge clk);
    attack_done = 1'b0;
    chk({nm, "_done"}, done, 1);
    @(negedge clk);
  endtask
`endif

  initial begin
    int rc;
    int pulses;
    int ntc;
    int seen;
    int b26;
    logic [7:0] l;
    logic [4:0] ei;
    logic [2:0] r0;
    logic [2:0] c0;

    vt[0] = '{25'h0, 25'h0, 2, 2, 1, 0};
    vt[1] = '{25'h00000E0, 25'h0000100, 6, 0, 1, 4};
    vt[2] = '{25'h00FFFFF, 25'h0F00000, 21, 1, 4, 4};
    vt[3] = '{25'h1FFFFFE, 25'h0, 22, 3, 0, 0};
    vt[4] = '{25'h1FFFFF7, 25'h0, 25, 0, 0, 3};

    rst = 1'b1;
    start = 1'b0;
    attack_done = 1'b0;
    board = '0;
    @(negedge clk);
    chk("rst_row", row, 0);
    chk("rst_col", col, 0);
    chk("rst_req", attack_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nt", no_target, 0);

    for (int n = 0; n < 5; n++) run_vec(n);

    // Full board: no_target after 26 cycles.
    do_reset();
    board = mk(~25'h0AAAAAA, 25'h0AAAAAA);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0;
    ntc = -1;
    seen = 0;
    b26 = -1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (attack_req) seen = 1;
      if (no_target) begin
        pulses++;
        if (ntc < 0) ntc = c;
      end
      if (c == 26) b26 = busy;
    end
    chk("nt_cycle", ntc, 26);
    chk("nt_pulses", pulses, 1);
    chk("nt_no_req", seen, 0);
    chk("nt_busy", b26, 0);

    // LFSR advance: start sampled after 3 free-running steps.
    do_reset();
    board = '0;
    repeat (3) @(negedge clk);
    l = 8'hA5;
    for (int i = 0; i < 3; i++) l = lstep(l);
    ei = (l[4:0] >= 5'd25) ? l[4:0] - 5'd25 : l[4:0];
    wait_req(rc);
    chk("lfsr_lat", rc, 2);
    chk("lfsr_row", row, int'(ei) / 5);
    chk("lfsr_col", col, int'(ei) % 5);

    // Holdoff with an ignored start during ISSUE.
    do_reset();
    board = '0;
    wait_req(rc);
    r0 = row;
    c0 = col;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      start = (c == 4);
      @(negedge clk);
      chk($sformatf("hold_req%0d", c), attack_req, 1);
      chk($sformatf("hold_rc%0d", c), {row, col}, {r0, c0});
      if (done) pulses++;
    end
    start = 1'b0;
    attack_done = 1'b1;
    @(negedge clk);
    attack_done = 1'b0;
    seen = 0;
    if (done) pulses++;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) pulses++;
      if (attack_req) seen = 1;
    end
    chk("hold_done_cnt", pulses, 1);
    chk("hold_no_requeue", seen, 0);

    // Reset during ISSUE.
    do_reset();
    board = '0;
    wait_req(rc);
    rst = 1'b1;
    #1;
    chk("mrst_req", attack_req, 0);
    chk("mrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    attack_done = 1'b1;
    @(negedge clk);
    attack_done = 1'b0;
    pulses = 0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || no_target) pulses++;
      if (attack_req) seen = 1;
    end
    chk("mrst_no_pulse", pulses, 0);
    chk("mrst_no_req", seen, 0);

`ifdef HUNT_MODE_EN
    // Hit at 12, north neighbour 7 open.
    do_reset();
    board = mk(25'h0000FE0, 25'h0);
    fire("hunt1", 2, 2, 12);
    board[7*5 +: 5] = 5'd0;
    fire("hunt_n", 1, 2, -1);
    // Hit at 12, north neighbour 7 already missed.
    do_reset();
    board = mk(25'h0000FE0, 25'h0);
    fire("hunt2", 2, 2, 12);
    fire("hunt_s", 3, 2, -1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
